// File: rtl/ym_bus_ctrl.sv
// rtl/ym_bus_ctrl.sv - PSG bus sequencer arbitrating CPU and replay-engine register accesses.
// Every bus/handshake output is a flop decoded from the next state, so pins change only on CLK.
module ym_bus_ctrl #(
   parameter int GAP_CYCLES = 1
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       CPU_REQ,
   input  logic       CPU_WE,
   input  logic [3:0] CPU_ADDR,
   input  logic [7:0] CPU_WDATA,
   output logic [7:0] CPU_RDATA,
   output logic       CPU_ACK,
   input  logic       RP_REQ,
   input  logic [3:0] RP_ADDR,
   input  logic [7:0] RP_WDATA,
   output logic       RP_ACK,
   output logic       BDIR,
   output logic       BC,
   output logic [7:0] DI,
   input  logic [7:0] DO,
   output logic       BUSY
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_DATA = 3'd2,
      S_READ = 3'd3,
      S_GAP  = 3'd4
   } state_t;

   localparam logic [1:0] GAP_LAST = 2'(GAP_CYCLES - 1);

   state_t     state_q, state_d;
   logic [1:0] gap_cnt_q, gap_cnt_d;
   logic       last_rp_q, last_rp_d;
   logic       gnt_rp_q, gnt_rp_d;
   logic       we_q, we_d;
   logic [3:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic       bdir_q, bdir_d;
   logic       bc_q, bc_d;
   logic [7:0] di_q, di_d;
   logic       cpu_ack_q, cpu_ack_d;
   logic       rp_ack_q, rp_ack_d;
   logic       busy_q, busy_d;
   logic [7:0] cpu_rdata_q, cpu_rdata_d;
   logic       pick_cpu;

   always_comb begin
      state_d     = state_q;
      gap_cnt_d   = gap_cnt_q;
      last_rp_d   = last_rp_q;
      gnt_rp_d    = gnt_rp_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      pick_cpu    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (CPU_REQ || RP_REQ) begin
               // Round-robin: on a tie the side not served last wins.
               pick_cpu  = CPU_REQ && (!RP_REQ || last_rp_q);
               gnt_rp_d  = !pick_cpu;
               last_rp_d = !pick_cpu;
               we_d      = pick_cpu ? CPU_WE    : 1'b1;
               addr_d    = pick_cpu ? CPU_ADDR  : RP_ADDR;
               wdata_d   = pick_cpu ? CPU_WDATA : RP_WDATA;
               state_d   = S_ADDR;
            end
         end
         S_ADDR: begin
            state_d = we_q ? S_DATA : S_READ;
         end
         S_DATA: begin
            gap_cnt_d = 2'd0;
            state_d   = S_GAP;
         end
         S_READ: begin
            cpu_rdata_d = DO;
            gap_cnt_d   = 2'd0;
            state_d     = S_GAP;
         end
         S_GAP: begin
            if (gap_cnt_q >= GAP_LAST) begin
               state_d = S_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 2'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      bdir_d    = 1'b0;
      bc_d      = 1'b0;
      di_d      = 8'h00;
      busy_d    = (state_d != S_IDLE);
      cpu_ack_d = 1'b0;
      rp_ack_d  = 1'b0;

      case (state_d)
         S_ADDR: begin
            bdir_d = 1'b1;
            bc_d   = 1'b1;
            di_d   = {4'h0, addr_d};
         end
         S_DATA: begin
            bdir_d = 1'b1;
            di_d   = wdata_d;
         end
         S_READ: begin
            bc_d = 1'b1;
         end
         default: begin
            bdir_d = 1'b0;
         end
      endcase

      // Acknowledge only on entry into GAP, never on later GAP cycles.
      if ((state_d == S_GAP) && (state_q != S_GAP)) begin
         cpu_ack_d = !gnt_rp_q;
         rp_ack_d  = gnt_rp_q;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= S_IDLE;
         gap_cnt_q   <= 2'd0;
         last_rp_q   <= 1'b1;
         gnt_rp_q    <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= 4'h0;
         wdata_q     <= 8'h00;
         bdir_q      <= 1'b0;
         bc_q        <= 1'b0;
         di_q        <= 8'h00;
         cpu_ack_q   <= 1'b0;
         rp_ack_q    <= 1'b0;
         busy_q      <= 1'b0;
         cpu_rdata_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         gap_cnt_q   <= gap_cnt_d;
         last_rp_q   <= last_rp_d;
         gnt_rp_q    <= gnt_rp_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         bdir_q      <= bdir_d;
         bc_q        <= bc_d;
         di_q        <= di_d;
         cpu_ack_q   <= cpu_ack_d;
         rp_ack_q    <= rp_ack_d;
         busy_q      <= busy_d;
         cpu_rdata_q <= cpu_rdata_d;
      end
   end

   assign BDIR      = bdir_q;
   assign BC        = bc_q;
   assign DI        = di_q;
   assign CPU_ACK   = cpu_ack_q;
   assign RP_ACK    = rp_ack_q;
   assign BUSY      = busy_q;
   assign CPU_RDATA = cpu_rdata_q;

endmodule

// File: doc/ym_bus_ctrl.md
YM_BUS_CTRL -- requirements
Module: ym_bus_ctrl

Interface
REQ-001 Parameter: GAP_CYCLES, default 1, number of idle cycles (BDIR=0, BC=0) driven after every transaction; legal range 1..3.
REQ-002 CLK  in  1  global clock; all state changes on rising edge.
REQ-003 RESET_N  in  1  reset; asynchronous assert, active-low.
REQ-004 CPU_REQ  in  1  CPU request; held high until CPU_ACK.
REQ-005 CPU_WE  in  1  1=write, 0=read; stable while CPU_REQ high.
REQ-006 CPU_ADDR  in  4  PSG register index 0..15.
REQ-007 CPU_WDATA  in  8  write data.
REQ-008 CPU_RDATA  out  8  read data; valid in the CPU_ACK cycle, held until the next CPU read completes.
REQ-009 CPU_ACK  out  1  one-cycle completion pulse.
REQ-010 RP_REQ  in  1  replay-engine write request; held high until RP_ACK.
REQ-011 RP_ADDR  in  4  register index.
REQ-012 RP_WDATA  in  8  write data.
REQ-013 RP_ACK  out  1  one-cycle completion pulse.
REQ-014 BDIR  out  1  PSG bus direction.
REQ-015 BC  out  1  PSG bus control.
REQ-016 DI  out  8  PSG data in.
REQ-017 DO  in  8  PSG data out; combinational from the PSG while BDIR=0 and BC=1.
REQ-018 BUSY  out  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have the states IDLE, ADDR, DATA, READ and GAP; BDIR, BC, DI, ACKs, CPU_RDATA and BUSY SHALL be registered outputs.
REQ-020 In IDLE the outputs SHALL be BDIR=0, BC=0, DI=00h; the FSM SHALL sample CPU_REQ/RP_REQ and, if either is high, latch the winner's addr, data and WE and enter ADDR on the next edge.
REQ-021 Arbitration SHALL be round-robin: if both requests are high, the requester not granted last SHALL win; after reset, the last grant SHALL be RP, so the CPU wins the first tie.
REQ-022 ADDR SHALL last exactly 1 cycle with BDIR=1, BC=1, DI={4'h0, addr}; the next state SHALL be DATA for a write and READ for a read.
REQ-023 DATA SHALL last 1 cycle with BDIR=1, BC=0, DI=data, then enter GAP.
REQ-024 READ SHALL last 1 cycle with BDIR=0, BC=1, DI=00h; DO SHALL be captured into CPU_RDATA at the end of the READ cycle, then the FSM SHALL enter GAP.
REQ-025 GAP SHALL last GAP_CYCLES cycles with BDIR=0, BC=0; the granted requester's ACK SHALL pulse high in the first GAP cycle only, then the FSM SHALL return to IDLE.
REQ-026 Latency from a request sampled in IDLE to ACK SHALL be 3 cycles for both writes and reads; a transaction SHALL occupy 3+GAP_CYCLES cycles, and the arbiter SHALL re-sample in IDLE.
REQ-027 The combination BDIR=0, BC=1 SHALL occur only in READ; BDIR=1 SHALL never be driven in consecutive transactions without an intervening GAP.
REQ-028 Requests deasserted before the grant SHALL be ignored; request or data changes after the grant SHALL NOT affect the transaction in flight.
REQ-029 A request high in the same cycle its ACK pulses SHALL be treated as a new request at the next IDLE.
REQ-030 RP writes SHALL never modify CPU_RDATA.

Reset
REQ-031 While RESET_N=0, the FSM SHALL be in IDLE, and BDIR, BC, DI, CPU_ACK, RP_ACK, BUSY and CPU_RDATA SHALL all be 0; the last grant SHALL be RP.
REQ-032 Reset asserted mid-transaction SHALL force the bus inactive immediately and asynchronously, with no ACK issued; the aborted request SHALL be re-served if still high after release.

Verification
REQ-033 CPU write addr=7, data=3Eh -> DI=07h with BDIR/BC=11, then DI=3Eh with BDIR/BC=10, then CPU_ACK pulse in GAP 3 cycles after grant.
REQ-034 CPU read addr=14 with DO=A5h in the READ cycle -> CPU_RDATA=A5h in the CPU_ACK cycle, and A5h held afterwards.
REQ-035 CPU_REQ and RP_REQ held high together for 4 transactions -> grants CPU, RP, CPU, RP; no overlapping ACKs.
REQ-036 RESET_N low during DATA -> BDIR=BC=0 within the same cycle, no ACK; after release, the still-high request completes normally.
REQ-037 GAP_CYCLES=3 with back-to-back RP writes -> 6 cycles per write, BDIR=0 and BC=0 for 3 cycles between transactions.
REQ-038 Change CPU_WDATA from 11h to 22h in the ADDR cycle -> DATA phase drives 11h.
